// File: rtl/pipe_stage_elastic.sv
// Elastic pipeline register: valid/ready handshake with a 2-entry (main + skid) buffer.
// Optional perf counters are built when PIPE_STAGE_ELASTIC_PERF_EN is defined.
module pipe_stage_elastic #(
  parameter int PAYLOAD_WIDTH  = 128,
  parameter int CLEAR_ON_FLUSH = 1,
  parameter int CNT_WIDTH      = 16
) (
  input  logic                     i_Clk,
  input  logic                     i_Reset_n,
  input  logic                     i_Flush,
  input  logic                     i_Valid,
  output logic                     o_Ready,
  input  logic [PAYLOAD_WIDTH-1:0] i_Payload,
  output logic                     o_Valid,
  input  logic                     i_Ready,
  output logic [PAYLOAD_WIDTH-1:0] o_Payload,
  output logic [1:0]               o_Occupancy
`ifdef PIPE_STAGE_ELASTIC_PERF_EN
  ,
  output logic [CNT_WIDTH-1:0]     o_Stall_Cycles,
  output logic [CNT_WIDTH-1:0]     o_Flushed_Beats
`endif
);

  if (PAYLOAD_WIDTH < 1 || CNT_WIDTH < 1) begin : g_bad_params
    $error("pipe_stage_elastic: widths must be >= 1");
  end

  logic                     main_valid, skid_valid;
  logic [PAYLOAD_WIDTH-1:0] main_q, skid_q;
  logic                     in_fire, out_fire;

  // Ready depends only on registered skid state, so i_Ready never reaches o_Ready.
  assign o_Ready     = ~skid_valid & i_Reset_n;
  assign o_Valid     = main_valid;
  assign o_Payload   = main_q;
  assign o_Occupancy = {skid_valid, main_valid & ~skid_valid};

  assign in_fire  = i_Valid & o_Ready;
  assign out_fire = main_valid & i_Ready;

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (i_Flush) begin
      main_valid <= 1'b0;
      skid_valid <= 1'b0;
      if (CLEAR_ON_FLUSH != 0) begin
        main_q <= '0;
        skid_q <= '0;
      end
    end else if (!main_valid) begin
      if (in_fire) begin
        main_q     <= i_Payload;
        main_valid <= 1'b1;
      end
    end else if (!skid_valid) begin
      if (in_fire && out_fire) begin
        main_q <= i_Payload;
      end else if (out_fire) begin
        main_valid <= 1'b0;
      end else if (in_fire) begin
        skid_q     <= i_Payload;
        skid_valid <= 1'b1;
      end
    end else if (out_fire) begin
      // Full: input is blocked, so the skid beat simply moves forward.
      main_q     <= skid_q;
      skid_valid <= 1'b0;
    end
  end

`ifdef PIPE_STAGE_ELASTIC_PERF_EN
  localparam logic [CNT_WIDTH+1:0] CNT_MAX = {2'b00, {CNT_WIDTH{1'b1}}};

  logic [CNT_WIDTH-1:0] stall_q, flushed_q;
  logic [CNT_WIDTH+1:0] flush_sum;

  assign flush_sum = {2'b00, flushed_q} + {{CNT_WIDTH{1'b0}}, o_Occupancy}
                   + {{(CNT_WIDTH+1){1'b0}}, in_fire};

  always_ff @(posedge i_Clk) begin
    if (!i_Reset_n) begin
      stall_q   <= '0;
      flushed_q <= '0;
    end else begin
      if (main_valid && !i_Ready && stall_q != {CNT_WIDTH{1'b1}})
        stall_q <= stall_q + 1'b1;
      if (i_Flush)
        flushed_q <= (flush_sum > CNT_MAX) ? {CNT_WIDTH{1'b1}} : flush_sum[CNT_WIDTH-1:0];
    end
  end

  assign o_Stall_Cycles  = stall_q;
  assign o_Flushed_Beats = flushed_q;
`endif

endmodule

// File: tb/tb_pipe_stage_elastic.sv
// Directed and random checks for pipe_stage_elastic; perf counter checks when
// PIPE_STAGE_ELASTIC_PERF_EN is defined.
module tb_pipe_stage_elastic;
  localparam int PW = 8;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_n, flush, in_valid, out_ready;
  logic [PW-1:0] in_payload;
  logic          ready, valid;
  logic [PW-1:0] payload;
  logic [1:0]    occ;
`ifdef PIPE_STAGE_ELASTIC_PERF_EN
  logic [CW-1:0] stall_cnt, flushed_cnt;
`endif

  int checks = 0;
  int errors = 0;

  pipe_stage_elastic #(.PAYLOAD_WIDTH(PW), .CLEAR_ON_FLUSH(1), .CNT_WIDTH(CW)) dut (
    .i_Clk(clk), .i_Reset_n(rst_n), .i_Flush(flush),
    .i_Valid(in_valid), .o_Ready(ready), .i_Payload(in_payload),
    .o_Valid(valid), .i_Ready(out_ready), .o_Payload(payload),
    .o_Occupancy(occ)
`ifdef PIPE_STAGE_ELASTIC_PERF_EN
    , .o_Stall_Cycles(stall_cnt), .o_Flushed_Beats(flushed_cnt)
`endif
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_payload = 8'hAA; out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (valid !== 1'b0 || payload !== 8'h00 || ready !== 1'b0 || occ !== 2'd0) begin
        errors++;
        $display("FAIL reset_hold cyc%0d got v=%b p=%h r=%b o=%0d want v=0 p=00 r=0 o=0",
                 i, valid, payload, ready, occ);
      end
    end
    rst_n = 1'b1; in_valid = 1'b0;
    #1;
    checks++;
    if (ready !== 1'b1 || occ !== 2'd0) begin
      errors++;
      $display("FAIL reset_release got r=%b o=%0d want r=1 o=0", ready, occ);
    end
`ifdef PIPE_STAGE_ELASTIC_PERF_EN
    checks++;
    if (stall_cnt !== 0 || flushed_cnt !== 0) begin
      errors++;
      $display("FAIL reset_counters got s=%0d f=%0d want 0 0", stall_cnt, flushed_cnt);
    end
`endif
  endtask

  task automatic test_back_to_back();
    out_ready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      in_valid = 1'b1; in_payload = PW'(i);
      tick();
      checks++;
      if (valid !== 1'b1 || payload !== PW'(i) || occ !== 2'd1 || ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_beat%0d got v=%b p=%h o=%0d r=%b want v=1 p=%h o=1 r=1",
                 i, valid, payload, occ, ready, PW'(i));
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (valid !== 1'b0 || occ !== 2'd0) begin
      errors++;
      $display("FAIL b2b_drain got v=%b o=%0d want v=0 o=0", valid, occ);
    end
  endtask

  task automatic test_backpressure();
    logic [PW-1:0] exp [3];
    exp[0] = 8'hA1; exp[1] = 8'hB2; exp[2] = 8'hC3;
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_payload = exp[i];
      tick();
    end
    checks++;
    if (payload !== 8'hA1 || valid !== 1'b1 || occ !== 2'd2 || ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_full got p=%h v=%b o=%0d r=%b want p=a1 v=1 o=2 r=0",
               payload, valid, occ, ready);
    end
    out_ready = 1'b1;
    for (int i = 1; i < 3; i++) begin
      tick();
      if (i == 2) in_valid = 1'b0;
      checks++;
      if (valid !== 1'b1 || payload !== exp[i]) begin
        errors++;
        $display("FAIL bp_drain%0d got v=%b p=%h want v=1 p=%h", i, valid, payload, exp[i]);
      end
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (valid !== 1'b0 || occ !== 2'd0) begin
      errors++;
      $display("FAIL bp_empty got v=%b o=%0d want v=0 o=0", valid, occ);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1;
    in_payload = 8'h11; tick();
    in_payload = 8'h22; tick();
    flush = 1'b1; in_payload = 8'h33; tick();
    flush = 1'b0; in_valid = 1'b0;
    checks++;
    if (valid !== 1'b0 || occ !== 2'd0 || payload !== 8'h00 || ready !== 1'b1) begin
      errors++;
      $display("FAIL flush_full got v=%b o=%0d p=%h r=%b want v=0 o=0 p=00 r=1",
               valid, occ, payload, ready);
    end
`ifdef PIPE_STAGE_ELASTIC_PERF_EN
    checks++;
    if (flushed_cnt !== 4'd2) begin
      errors++;
      $display("FAIL flush_count_full got %0d want 2", flushed_cnt);
    end
`endif
    in_valid = 1'b1; in_payload = 8'h44; tick();
    flush = 1'b1; in_payload = 8'h55; tick();
    flush = 1'b0; in_valid = 1'b0;
    tick();
    checks++;
    if (valid !== 1'b0 || occ !== 2'd0) begin
      errors++;
      $display("FAIL flush_infire got v=%b o=%0d want v=0 o=0", valid, occ);
    end
`ifdef PIPE_STAGE_ELASTIC_PERF_EN
    checks++;
    if (flushed_cnt !== 4'd4) begin
      errors++;
      $display("FAIL flush_count_infire got %0d want 4", flushed_cnt);
    end
`endif
  endtask

  task automatic test_reset_vs_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_payload = 8'h66;
    tick();
    rst_n = 1'b0; flush = 1'b1;
    tick();
    checks++;
    if (valid !== 1'b0 || payload !== 8'h00 || occ !== 2'd0 || ready !== 1'b0) begin
      errors++;
      $display("FAIL rst_flush got v=%b p=%h o=%0d r=%b want v=0 p=00 o=0 r=0",
               valid, payload, occ, ready);
    end
`ifdef PIPE_STAGE_ELASTIC_PERF_EN
    checks++;
    if (stall_cnt !== 0 || flushed_cnt !== 0) begin
      errors++;
      $display("FAIL rst_flush_counters got s=%0d f=%0d want 0 0", stall_cnt, flushed_cnt);
    end
`endif
    rst_n = 1'b1; flush = 1'b0; in_valid = 1'b0;
    tick();
  endtask

  task automatic test_random();
    logic [PW-1:0] q[$];
    logic          m_in, m_out;
    int            bad = 0;
    for (int c = 0; c < 10000; c++) begin
      in_valid   = 1'($urandom_range(0, 1));
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 99) < 5);
      in_payload = PW'($urandom);
      m_in  = in_valid && (q.size() < 2);
      m_out = out_ready && (q.size() > 0);
      tick();
      if (flush) q.delete();
      else begin
        if (m_out) void'(q.pop_front());
        if (m_in) q.push_back(in_payload);
      end
      checks++;
      if (valid !== (q.size() > 0) || occ !== 2'(q.size()) || ready !== (q.size() < 2) ||
          (q.size() > 0 && payload !== q[0])) begin
        errors++;
        bad++;
        if (bad <= 10)
          $display("FAIL random cyc%0d got v=%b o=%0d r=%b p=%h want o=%0d p=%h",
                   c, valid, occ, ready, payload, q.size(), (q.size() > 0) ? q[0] : 8'h00);
      end
    end
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    tick(); tick();
  endtask

`ifdef PIPE_STAGE_ELASTIC_PERF_EN
  task automatic test_stall_saturation();
    rst_n = 1'b0; tick();
    rst_n = 1'b1; out_ready = 1'b0; in_valid = 1'b1; in_payload = 8'h77;
    tick();
    in_valid = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (i == 9) begin
        checks++;
        if (stall_cnt !== 4'd10) begin
          errors++;
          $display("FAIL stall_mid got %0d want 10", stall_cnt);
        end
      end
    end
    checks++;
    if (stall_cnt !== 4'd15) begin
      errors++;
      $display("FAIL stall_saturate got %0d want 15", stall_cnt);
    end
    out_ready = 1'b1; tick();
  endtask
`endif

  initial begin
    test_reset();
    test_back_to_back();
    test_backpressure();
    test_flush();
    test_reset_vs_flush();
    test_random();
`ifdef PIPE_STAGE_ELASTIC_PERF_EN
    test_stall_saturation();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
